// File: rtl/mbist_march_ctrl_if.sv
// BIST-side signal bundle between the March C- controller, the memory mux and the repair logic.
interface mbist_march_ctrl_if #(
  parameter int unsigned ADDR_WD = 9,
  parameter int unsigned DATA_WD = 32
) ();
  logic               bist_run;
  logic               bist_pat_sel;
  logic [DATA_WD-1:0] mem_rdata;
  logic               bist_correct;
  logic               bist_en;
  logic [ADDR_WD-1:0] bist_addr;
  logic [DATA_WD-1:0] bist_wdata;
  logic               bist_wr;
  logic               bist_rd;
  logic               bist_error;
  logic [ADDR_WD-1:0] bist_error_addr;
  logic               bist_done;
  logic               bist_pass;
  logic               bist_fail;
  logic               bist_repair_used;

  modport master (
    input  bist_run, bist_pat_sel, mem_rdata, bist_correct,
    output bist_en, bist_addr, bist_wdata, bist_wr, bist_rd, bist_error,
           bist_error_addr, bist_done, bist_pass, bist_fail, bist_repair_used
  );

  modport slave (
    output bist_run, bist_pat_sel, mem_rdata, bist_correct,
    input  bist_en, bist_addr, bist_wdata, bist_wr, bist_rd, bist_error,
           bist_error_addr, bist_done, bist_pass, bist_fail, bist_repair_used
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer for one dual-port SRAM (A reads, B writes) with first-miscompare
// reporting and a single repair-and-rerun pass.
module mbist_march_ctrl #(
  parameter int unsigned               BIST_ADDR_WD    = 9,
  parameter int unsigned               BIST_DATA_WD    = 32,
  parameter logic [BIST_ADDR_WD-1:0]   BIST_ADDR_START = '0,
  parameter logic [BIST_ADDR_WD-1:0]   BIST_ADDR_END   = BIST_ADDR_WD'(9'h1F8)
) (
  input  logic               bist_clk,
  input  logic               bist_rst,
  mbist_march_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_ERR    = 3'd3;
  localparam logic [2:0] ST_REPAIR = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [BIST_DATA_WD-1:0] PAT_CHK = {BIST_DATA_WD/2{2'b01}};

  logic [2:0]              state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [BIST_ADDR_WD-1:0] addr_q, addr_d;
  logic [BIST_DATA_WD-1:0] wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic [BIST_DATA_WD-1:0] bg_q, bg_d;
  logic                    cmp_vld_q, cmp_vld_d;
  logic [BIST_DATA_WD-1:0] cmp_exp_q, cmp_exp_d;
  logic [BIST_ADDR_WD-1:0] cmp_addr_q, cmp_addr_d;
  logic [BIST_ADDR_WD-1:0] err_addr_q, err_addr_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;
  logic                    rep_used_q, rep_used_d;
  logic [1:0]              tmr_q, tmr_d;

  logic                    at_end;
  logic [BIST_ADDR_WD-1:0] step_addr;
  logic [BIST_ADDR_WD-1:0] first_addr;
  logic [2:0]              nx_elem;
  logic [BIST_ADDR_WD-1:0] nx_addr;
  logic                    nx_wr;
  logic                    nx_last;
  logic                    mismatch;
  logic                    start_op;
  logic                    advance;

  // The registered strobe/address/element describe the op on the bus this cycle and
  // double as the walk cursor; this block derives the op for the following cycle.
  always_comb begin
    at_end     = (elem_q <= 3'd2) ? (addr_q == BIST_ADDR_END) : (addr_q == BIST_ADDR_START);
    step_addr  = (elem_q <= 3'd2) ? addr_q + 1'b1 : addr_q - 1'b1;
    first_addr = (elem_q < 3'd2) ? BIST_ADDR_START : BIST_ADDR_END;
    nx_elem    = elem_q;
    nx_addr    = addr_q;
    nx_wr      = 1'b0;
    nx_last    = 1'b0;
    if (elem_q == 3'd0) begin
      if (at_end) begin
        nx_elem = 3'd1;
        nx_addr = BIST_ADDR_START;
      end else begin
        nx_addr = step_addr;
        nx_wr   = 1'b1;
      end
    end else if (elem_q == 3'd5) begin
      if (at_end) nx_last = 1'b1;
      else        nx_addr = step_addr;
    end else if (rd_q) begin
      nx_wr = 1'b1;
    end else if (at_end) begin
      nx_elem = elem_q + 3'd1;
      nx_addr = first_addr;
    end else begin
      nx_addr = step_addr;
    end
  end

  assign mismatch = cmp_vld_q && (bus.mem_rdata != cmp_exp_q);

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    bg_d       = bg_q;
    cmp_vld_d  = rd_q;
    cmp_exp_d  = cmp_exp_q;
    cmp_addr_d = cmp_addr_q;
    err_addr_d = err_addr_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    rep_used_d = rep_used_q;
    tmr_d      = tmr_q;
    start_op   = 1'b0;
    advance    = 1'b0;

    if (rd_q) begin
      cmp_exp_d  = elem_q[0] ? bg_q : ~bg_q;
      cmp_addr_d = addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.bist_run) begin
          state_d    = ST_RUN;
          bg_d       = bus.bist_pat_sel ? PAT_CHK : '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          rep_used_d = 1'b0;
          start_op   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.bist_run) begin
          state_d = ST_IDLE;
        end else if (mismatch) begin
          state_d    = ST_ERR;
          err_addr_d = cmp_addr_q;
        end else if (nx_last) begin
          state_d = ST_DRAIN;
        end else begin
          advance = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!bus.bist_run) begin
          state_d = ST_IDLE;
        end else if (mismatch) begin
          state_d    = ST_ERR;
          err_addr_d = cmp_addr_q;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end
      end
      ST_ERR: begin
        if (!bus.bist_run) begin
          state_d = ST_IDLE;
        end else if (rep_used_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fail_d  = 1'b1;
        end else begin
          state_d = ST_REPAIR;
          tmr_d   = '0;
        end
      end
      ST_REPAIR: begin
        if (!bus.bist_run) begin
          state_d = ST_IDLE;
        end else if (bus.bist_correct) begin
          state_d    = ST_RUN;
          rep_used_d = 1'b1;
          start_op   = 1'b1;
        end else if (tmr_q == 2'd3) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fail_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (!bus.bist_run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_op) begin
      elem_d  = '0;
      addr_d  = BIST_ADDR_START;
      wr_d    = 1'b1;
      wdata_d = bg_d;
    end else if (advance) begin
      elem_d = nx_elem;
      addr_d = nx_addr;
      wr_d   = nx_wr;
      rd_d   = !nx_wr;
      if (nx_wr) wdata_d = nx_elem[0] ? ~bg_q : bg_q;
    end
  end

  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      state_q    <= ST_IDLE;
      elem_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      bg_q       <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_addr_q <= '0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      rep_used_q <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      bg_q       <= bg_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_exp_q  <= cmp_exp_d;
      cmp_addr_q <= cmp_addr_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      rep_used_q <= rep_used_d;
      tmr_q      <= tmr_d;
    end
  end

  assign bus.bist_en          = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                                (state_q == ST_ERR) || (state_q == ST_REPAIR);
  assign bus.bist_addr        = addr_q;
  assign bus.bist_wdata       = wdata_q;
  assign bus.bist_wr          = wr_q;
  assign bus.bist_rd          = rd_q;
  assign bus.bist_error       = (state_q == ST_ERR);
  assign bus.bist_error_addr  = err_addr_q;
  assign bus.bist_done        = done_q;
  assign bus.bist_pass        = pass_q;
  assign bus.bist_fail        = fail_q;
  assign bus.bist_repair_used = rep_used_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: clean runs, both backgrounds, repair, timeout, abort, reset.
module tb_mbist_march_ctrl;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   test_id  = 0;
  int   used_id  = -1;
  logic          fault_once;
  logic          fault_stuck;
  logic [AW-1:0] fault_addr;
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];

  mbist_march_ctrl_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus ();
  mbist_march_ctrl_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus1 ();

  mbist_march_ctrl #(
    .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW),
    .BIST_ADDR_START(9'h000), .BIST_ADDR_END(9'h003)
  ) dut (.bist_clk(clk), .bist_rst(rst), .bus(bus));

  mbist_march_ctrl #(
    .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW),
    .BIST_ADDR_START(9'h005), .BIST_ADDR_END(9'h005)
  ) dut1 (.bist_clk(clk), .bist_rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Memory model: port B writes on the edge, port A read data appears the next cycle.
  always @(posedge clk) begin
    if (bus.bist_wr) mem[bus.bist_addr] <= bus.bist_wdata;
    if (bus.bist_rd) begin
      if ((bus.bist_addr == fault_addr) && (fault_stuck || (fault_once && used_id != test_id))) begin
        bus.mem_rdata <= mem[bus.bist_addr] ^ 32'h0000_0100;
        used_id       <= test_id;
      end else begin
        bus.mem_rdata <= mem[bus.bist_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (bus1.bist_wr) mem1[bus1.bist_addr] <= bus1.bist_wdata;
    if (bus1.bist_rd) bus1.mem_rdata <= mem1[bus1.bist_addr];
  end

  function automatic logic [7:0] st();
    return {bus.bist_en, bus.bist_wr, bus.bist_rd, bus.bist_error,
            bus.bist_done, bus.bist_pass, bus.bist_fail, bus.bist_repair_used};
  endfunction

  function automatic logic [7:0] st1();
    return {bus1.bist_en, bus1.bist_wr, bus1.bist_rd, bus1.bist_error,
            bus1.bist_done, bus1.bist_pass, bus1.bist_fail, bus1.bist_repair_used};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.bist_run = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.bist_run = 1'b0; bus.bist_pat_sel = 1'b0; bus.bist_correct = 1'b0;
    bus1.bist_run = 1'b0; bus1.bist_pat_sel = 1'b0; bus1.bist_correct = 1'b0;
    fault_once = 1'b0; fault_stuck = 1'b0; fault_addr = '0;
    tick();
    tick();
    n_checks++;
    if (st() !== 8'h00) $display("FAIL reset_status: got %b want %b", st(), 8'h00);
    else n_pass++;
    n_checks++;
    if ({bus.bist_addr, bus.bist_wdata, bus.bist_error_addr} !== '0)
      $display("FAIL reset_bus: got addr=%h wdata=%h eaddr=%h want 0", bus.bist_addr, bus.bist_wdata, bus.bist_error_addr);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_pat0();
    int errs = 0;
    int both = 0;
    test_id = 1;
    bus.bist_pat_sel = 1'b0;
    bus.bist_run = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (bus.bist_error) errs++;
      if (bus.bist_wr && bus.bist_rd) both++;
      if (k <= 4) begin
        n_checks++;
        if ({bus.bist_wr, bus.bist_rd, bus.bist_addr, bus.bist_wdata} !== {1'b1, 1'b0, 9'(k-1), 32'h0})
          $display("FAIL clean_e0_write[%0d]: got wr=%b rd=%b addr=%h wdata=%h want wr=1 rd=0 addr=%h wdata=0",
                   k, bus.bist_wr, bus.bist_rd, bus.bist_addr, bus.bist_wdata, k-1);
        else n_pass++;
      end
      if (k == 5 || k == 40) begin
        n_checks++;
        if ({bus.bist_wr, bus.bist_rd, bus.bist_addr} !== {1'b0, 1'b1, 9'h000})
          $display("FAIL clean_read[%0d]: got wr=%b rd=%b addr=%h want wr=0 rd=1 addr=000", k, bus.bist_wr, bus.bist_rd, bus.bist_addr);
        else n_pass++;
      end
      if (k == 41) begin
        n_checks++;
        if (st() !== 8'b1000_0000) $display("FAIL clean_drain: got %b want %b", st(), 8'b1000_0000);
        else n_pass++;
      end
      if (k == 42) begin
        n_checks++;
        if (st() !== 8'b0000_1100) $display("FAIL clean_done: got %b want %b", st(), 8'b0000_1100);
        else n_pass++;
      end
    end
    n_checks++;
    if (errs !== 0) $display("FAIL clean_no_error: got %0d pulses want 0", errs);
    else n_pass++;
    n_checks++;
    if (both !== 0) $display("FAIL clean_exclusive: got %0d overlaps want 0", both);
    else n_pass++;
  endtask

  task automatic test_pattern_sel();
    test_id = 2;
    bus.bist_run = 1'b0;
    tick();
    n_checks++;
    if (st() !== 8'b0000_1100) $display("FAIL idle_status_held: got %b want %b", st(), 8'b0000_1100);
    else n_pass++;
    bus.bist_pat_sel = 1'b1;
    bus.bist_run = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k == 2) bus.bist_pat_sel = 1'b0;
      if (k == 1) begin
        n_checks++;
        if ({st(), bus.bist_wdata} !== {8'b1100_0000, 32'h5555_5555})
          $display("FAIL pat_start: got st=%b wdata=%h want st=11000000 wdata=55555555", st(), bus.bist_wdata);
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if ({bus.bist_wr, bus.bist_addr, bus.bist_wdata} !== {1'b1, 9'h000, 32'hAAAA_AAAA})
          $display("FAIL pat_e1_write: got wr=%b addr=%h wdata=%h want wr=1 addr=000 wdata=aaaaaaaa", bus.bist_wr, bus.bist_addr, bus.bist_wdata);
        else n_pass++;
      end
      if (k == 14) begin
        n_checks++;
        if ({bus.bist_wr, bus.bist_addr, bus.bist_wdata} !== {1'b1, 9'h000, 32'h5555_5555})
          $display("FAIL pat_e2_write: got wr=%b addr=%h wdata=%h want wr=1 addr=000 wdata=55555555", bus.bist_wr, bus.bist_addr, bus.bist_wdata);
        else n_pass++;
      end
      if (k == 42) begin
        n_checks++;
        if (st() !== 8'b0000_1100) $display("FAIL pat_done: got %b want %b", st(), 8'b0000_1100);
        else n_pass++;
      end
    end
  endtask

  task automatic test_repair_pass();
    int errs = 0;
    go_idle();
    test_id = 3;
    fault_once = 1'b1; fault_addr = 9'h002;
    bus.bist_run = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      tick();
      if (bus.bist_error) errs++;
      if (k == 11) begin
        n_checks++;
        if ({st(), bus.bist_error_addr} !== {8'b1001_0000, 9'h002})
          $display("FAIL rep_error_pulse: got st=%b eaddr=%h want st=10010000 eaddr=002", st(), bus.bist_error_addr);
        else n_pass++;
      end
      if (k == 12) begin
        n_checks++;
        if (st() !== 8'b1000_0000) $display("FAIL rep_waiting: got %b want %b", st(), 8'b1000_0000);
        else n_pass++;
      end
      if (k == 13) bus.bist_correct = 1'b1;
      if (k == 14) begin
        bus.bist_correct = 1'b0;
        n_checks++;
        if ({st(), bus.bist_addr, bus.bist_wdata} !== {8'b1100_0001, 9'h000, 32'h0})
          $display("FAIL rep_restart: got st=%b addr=%h wdata=%h want st=11000001 addr=000 wdata=0", st(), bus.bist_addr, bus.bist_wdata);
        else n_pass++;
      end
      if (k == 54) begin
        n_checks++;
        if (st() !== 8'b1000_0001) $display("FAIL rep_drain: got %b want %b", st(), 8'b1000_0001);
        else n_pass++;
      end
      if (k == 55) begin
        n_checks++;
        if (st() !== 8'b0000_1101) $display("FAIL rep_done_pass: got %b want %b", st(), 8'b0000_1101);
        else n_pass++;
      end
    end
    n_checks++;
    if (errs !== 1) $display("FAIL rep_error_count: got %0d pulses want 1", errs);
    else n_pass++;
    fault_once = 1'b0;
  endtask

  task automatic test_persistent_fault();
    go_idle();
    test_id = 4;
    fault_stuck = 1'b1; fault_addr = 9'h001;
    bus.bist_run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 9 || k == 19) begin
        n_checks++;
        if ({bus.bist_error, bus.bist_en, bus.bist_error_addr} !== {1'b1, 1'b1, 9'h001})
          $display("FAIL stuck_error[%0d]: got err=%b en=%b eaddr=%h want err=1 en=1 eaddr=001", k, bus.bist_error, bus.bist_en, bus.bist_error_addr);
        else n_pass++;
      end
      if (k == 10) bus.bist_correct = 1'b1;
      if (k == 11) begin
        bus.bist_correct = 1'b0;
        n_checks++;
        if ({st(), bus.bist_addr} !== {8'b1100_0001, 9'h000})
          $display("FAIL stuck_restart: got st=%b addr=%h want st=11000001 addr=000", st(), bus.bist_addr);
        else n_pass++;
      end
      if (k == 20) begin
        n_checks++;
        if (st() !== 8'b0000_1011) $display("FAIL stuck_done_fail: got %b want %b", st(), 8'b0000_1011);
        else n_pass++;
      end
    end
    fault_stuck = 1'b0;
  endtask

  task automatic test_repair_timeout();
    go_idle();
    test_id = 5;
    fault_once = 1'b1; fault_addr = 9'h002;
    bus.bist_correct = 1'b0;
    bus.bist_run = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) begin
        n_checks++;
        if (st() !== 8'b1100_0000) $display("FAIL tmo_status_clear: got %b want %b", st(), 8'b1100_0000);
        else n_pass++;
      end
      if (k == 15) begin
        n_checks++;
        if (st() !== 8'b1000_0000) $display("FAIL tmo_last_wait: got %b want %b", st(), 8'b1000_0000);
        else n_pass++;
      end
      if (k == 16) begin
        n_checks++;
        if (st() !== 8'b0000_1010) $display("FAIL tmo_done_fail: got %b want %b", st(), 8'b0000_1010);
        else n_pass++;
      end
    end
    fault_once = 1'b0;
  endtask

  task automatic test_abort();
    go_idle();
    test_id = 6;
    bus.bist_run = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 10) bus.bist_run = 1'b0;
      if (k == 11 || k == 13) begin
        n_checks++;
        if (st() !== 8'h00) $display("FAIL abort_idle[%0d]: got %b want %b", k, st(), 8'h00);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    test_id = 7;
    bus.bist_pat_sel = 1'b1;
    bus.bist_run = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    n_checks++;
    if ({bus.bist_rd, bus.bist_addr} !== {1'b1, 9'h001})
      $display("FAIL midrun_read: got rd=%b addr=%h want rd=1 addr=001", bus.bist_rd, bus.bist_addr);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({st(), bus.bist_addr, bus.bist_wdata, bus.bist_error_addr} !== '0)
      $display("FAIL midrun_reset: got st=%b addr=%h wdata=%h eaddr=%h want all 0", st(), bus.bist_addr, bus.bist_wdata, bus.bist_error_addr);
    else n_pass++;
    rst = 1'b0;
    bus.bist_run = 1'b0;
    tick();
  endtask

  task automatic test_single_address();
    bus1.bist_pat_sel = 1'b0;
    bus1.bist_run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1 || k == 3) begin
        n_checks++;
        if ({bus1.bist_wr, bus1.bist_addr, bus1.bist_wdata} !== {1'b1, 9'h005, (k == 1) ? 32'h0 : 32'hFFFF_FFFF})
          $display("FAIL one_addr_write[%0d]: got wr=%b addr=%h wdata=%h", k, bus1.bist_wr, bus1.bist_addr, bus1.bist_wdata);
        else n_pass++;
      end
      if (k == 10) begin
        n_checks++;
        if ({bus1.bist_rd, bus1.bist_addr} !== {1'b1, 9'h005})
          $display("FAIL one_addr_last_read: got rd=%b addr=%h want rd=1 addr=005", bus1.bist_rd, bus1.bist_addr);
        else n_pass++;
      end
      if (k == 12) begin
        n_checks++;
        if (st1() !== 8'b0000_1100) $display("FAIL one_addr_done: got %b want %b", st1(), 8'b0000_1100);
        else n_pass++;
      end
    end
    bus1.bist_run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_pat0();
    test_pattern_sel();
    test_repair_pass();
    test_persistent_fault();
    test_repair_timeout();
    test_abort();
    test_reset_midrun();
    test_single_address();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- sequencer that drives the BIST side of the memory mux and repair path for one dual-port SRAM: port A reads, port B writes. It generates address, data, read and write strobes, compares read data, and reports the first miscompare to the repair logic. After a successful repair it reruns the whole algorithm once. It sits between the top-level test-control registers and the memory mux.

## Interface
- BIST_ADDR_WD, 9, memory address width
- BIST_DATA_WD, 32, memory data width
- BIST_ADDR_START, 9'h000, first tested address; must be <= BIST_ADDR_END
- BIST_ADDR_END, 9'h1F8, last tested address
- bist_clk  in  1  sole clock; memory and controller both run on it
- bist_rst  in  1  synchronous, active-high reset
- bist_run  in  1  level; rising use starts test from IDLE, deassertion aborts
- bist_pat_sel  in  1  background select: 0 = all-0/all-1, 1 = 0x55../0xAA..
- mem_rdata  in  BIST_DATA_WD  port-A read data, valid the cycle after bist_rd
- bist_correct  in  1  repair logic reports the remap is active
- bist_en  out  1  BIST owns the memory
- bist_addr  out  BIST_ADDR_WD  address for the current operation
- bist_wdata  out  BIST_DATA_WD  write data
- bist_wr  out  1  write strobe, port B
- bist_rd  out  1  read strobe, port A
- bist_error  out  1  one-cycle miscompare pulse sent to the repair logic
- bist_error_addr  out  BIST_ADDR_WD  address of the last miscompare; held
- bist_done, bist_pass, bist_fail  out  1 each  completion status; held
- bist_repair_used  out  1  one repair has been consumed

## Operation
- States:
  - IDLE.
  - RUN: issues operations.
  - DRAIN: one cycle, final compare.
  - ERR: error pulse.
  - REPAIR: waits for bist_correct.
  - DONE.
- Elements, in order, with D0 = background and D1 = ~D0:
  - E0: up, W D0.
  - E1: up, R D0 then W D1.
  - E2: up, R D1 then W D0.
  - E3: down, R D0 then W D1.
  - E4: down, R D1 then W D0.
  - E5: down, R D0.
- Background: D0 is all zeros when bist_pat_sel=0, or {BIST_DATA_WD/2{2'b01}} when bist_pat_sel=1. bist_pat_sel is sampled at start and ignored during the run.
- Address walk:
  - Up runs START..END, incrementing by 1; down runs END..START, decrementing by 1.
  - The counter never wraps; element end is detected by equality.
  - START==END is legal: one address per element.
- Issue rate: one operation per cycle, so a read/write pair takes two cycles at the same address. For A addresses the run issues N = 10*A operations.
- Compare stage:
  - Every read registers {expected data, address} with a valid flag.
  - On the next cycle that flag qualifies a compare of mem_rdata against expected.
  - A mismatch moves the FSM to ERR at the following edge. Operations already issued complete; no new ones are issued.
- ERR:
  - bist_error=1 for exactly one cycle, with bist_error_addr = the failing address.
  - Then, if bist_repair_used=0, go to REPAIR; otherwise go to DONE with fail.
- REPAIR:
  - Waits up to 4 cycles for bist_correct=1.
  - If seen: set bist_repair_used and restart at E0, START.
  - On timeout: DONE with fail.
- DONE:
  - bist_done=1, with exactly one of pass/fail set; bist_en=0.
  - Leaves for IDLE when bist_run=0.
  - Status stays held through IDLE and clears on the next start.
- bist_run=0 in RUN, DRAIN, ERR or REPAIR: go to IDLE at the next edge, drop all strobes, leave bist_done=0.

## Timing
- Reset: every output is 0, state is IDLE, and bist_repair_used is cleared.
- bist_run=1 sampled in IDLE at cycle c:
  - Status clears at c+1.
  - bist_en=1 from c+1, and the first write is at c+1.
  - Operations occupy c+1..c+N.
  - DRAIN is at c+N+1.
  - bist_done/bist_pass are 1 from c+N+2.
- bist_wr and bist_rd are mutually exclusive and never both 1.
- bist_addr and bist_wdata are valid only while a strobe is 1 and hold their value otherwise.
- Miscompare:
  - Read at cycle t, compare at t+1.
  - bist_error=1 at t+2, with bist_en still 1.
- bist_en=1 in RUN, DRAIN, ERR and REPAIR, and 0 otherwise.
- Reset mid-run behaves identically to reset from IDLE: outputs are 0 on the next edge.

## Test plan
- Clean memory, START=0, END=3, pat_sel=0, run at cycle 0:
  - N=40; writes at cycles 1-4 with data 0.
  - done=1, pass=1 at cycle 42; no bist_error.
- pat_sel=1 on the same memory: E0 writes 0x55555555; E1's write is 0xAAAAAAAA; pass at cycle 42.
- Force address 2's read to return wrong data once:
  - bist_error pulses for one cycle with error_addr=2.
  - Drive bist_correct=1 two cycles later: restart at E0 with repair_used=1, then pass.
- Persistent fault at address 1:
  - The first error is repaired.
  - The second error at address 1 gives done=1, fail=1, repair_used=1.
- First error with bist_correct held at 0: done=1, fail=1 exactly 4 cycles after REPAIR is entered.
- Deassert bist_run at cycle 10: at cycle 11 bist_en=0, wr=rd=0, done=0. Assert bist_rst mid-run: all outputs 0 after the next edge.
